// File: rtl/neuron_act.sv
// neuron_act: bias add, ReLU, requantize/saturate and output FIFO for one neuron lane.
// Optional feature macro: LEAKY_RELU_EN (negative sums scaled by 1/8 instead of zeroed).
module neuron_act #(
    parameter int DIN_WIDTH  = 32,
    parameter int DIN_INT    = 14,
    parameter int BIAS_WIDTH = 16,
    parameter int BIAS_INT   = 4,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_INT   = 4,
    parameter int N_NEURONS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DIN_WIDTH-1:0]   din,
    input  logic                          din_valid,
    input  logic                          bias_we,
    input  logic [$clog2(N_NEURONS)-1:0]  bias_addr,
    input  logic signed [BIAS_WIDTH-1:0]  bias_din,
    output logic signed [DOUT_WIDTH-1:0]  dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(N_NEURONS)-1:0]  dout_idx,
    output logic                          overflow
);
    localparam int IDX_W      = $clog2(N_NEURONS);
    localparam int SUM_W      = DIN_WIDTH + 1;
    localparam int DIN_FRAC   = DIN_WIDTH - DIN_INT;
    localparam int BIAS_SHIFT = DIN_FRAC - (BIAS_WIDTH - BIAS_INT);
    localparam int OUT_SHIFT  = DIN_FRAC - (DOUT_WIDTH - DOUT_INT);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W    = DOUT_WIDTH + IDX_W;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic signed [BIAS_WIDTH-1:0] bias_reg [N_NEURONS];
    logic [IDX_W-1:0]             idx_reg;

    logic signed [SUM_W-1:0] sum_reg;
    logic                    s1_valid_reg;
    logic [IDX_W-1:0]        s1_idx_reg;

    logic signed [DOUT_WIDTH-1:0] s2_val_reg;
    logic                         s2_valid_reg;
    logic [IDX_W-1:0]             s2_idx_reg;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               overflow_reg;

    // Bias bank: a read in the same cycle as a write to that address sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                bias_reg[i] <= '0;
            end
        end else if (bias_we) begin
            bias_reg[bias_addr] <= bias_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg <= '0;
        end else if (din_valid) begin
            if (idx_reg == IDX_W'(N_NEURONS - 1)) begin
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    // Stage 1: align the bias to the accumulator's binary point and add.
    logic signed [BIAS_WIDTH-1:0] bias_word;
    logic signed [SUM_W-1:0]      din_ext;
    logic signed [SUM_W-1:0]      bias_ext;
    logic signed [SUM_W-1:0]      sum_next;

    assign bias_word = bias_reg[idx_reg];
    assign din_ext   = {din[DIN_WIDTH-1], din};
    assign bias_ext  = {{(SUM_W-BIAS_WIDTH){bias_word[BIAS_WIDTH-1]}}, bias_word};
    assign sum_next  = din_ext + (bias_ext <<< BIAS_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_idx_reg   <= '0;
        end else begin
            sum_reg      <= sum_next;
            s1_valid_reg <= din_valid;
            s1_idx_reg   <= idx_reg;
        end
    end

    // Stage 2: activation, truncating requantize, saturation.
    logic signed [SUM_W-1:0]      act_next;
    logic signed [SUM_W-1:0]      scaled_next;
    logic signed [DOUT_WIDTH-1:0] sat_next;

    always_comb begin
        act_next = sum_reg;
        if (sum_reg[SUM_W-1]) begin
`ifdef LEAKY_RELU_EN
            act_next = sum_reg >>> 3;
`else
            act_next = '0;
`endif
        end
        scaled_next = act_next >>> OUT_SHIFT;
        if (scaled_next > SAT_MAX) begin
            sat_next = SAT_MAX[DOUT_WIDTH-1:0];
        end else if (scaled_next < SAT_MIN) begin
            sat_next = SAT_MIN[DOUT_WIDTH-1:0];
        end else begin
            sat_next = scaled_next[DOUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_val_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_idx_reg   <= '0;
        end else begin
            s2_val_reg   <= sat_next;
            s2_valid_reg <= s1_valid_reg;
            s2_idx_reg   <= s1_idx_reg;
        end
    end

    // Output FIFO: a push into a full FIFO survives only if the head leaves that cycle.
    logic fifo_full;
    logic fifo_pop;
    logic fifo_push;
    logic fifo_drop;

    assign fifo_full = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_pop  = dout_valid && dout_ready;
    assign fifo_push = s2_valid_reg && (!fifo_full || fifo_pop);
    assign fifo_drop = s2_valid_reg && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr_reg] <= {s2_val_reg, s2_idx_reg};
                wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (fifo_pop && !fifo_push) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
            if (fifo_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    logic [ENTRY_W-1:0] head_entry;

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign dout       = head_entry[ENTRY_W-1:IDX_W];
    assign dout_idx   = head_entry[IDX_W-1:0];
    assign dout_valid = (count_reg != '0);
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_neuron_act.sv
// Directed testbench for neuron_act: bias add, activation, saturation, index wrap,
// backpressure/overflow and asynchronous reset.
module tb_neuron_act;
    logic               clk;
    logic               rst;
    logic signed [31:0] din;
    logic               din_valid;
    logic               bias_we;
    logic [2:0]         bias_addr;
    logic signed [15:0] bias_din;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         dout_idx;
    logic               overflow;

    int n_checks = 0;
    int n_errors = 0;

`ifdef LEAKY_RELU_EN
    localparam longint NEG_EXP     = -1024;
    localparam longint BIG_NEG_EXP = -32768;
`else
    localparam longint NEG_EXP     = 0;
    localparam longint BIG_NEG_EXP = 0;
`endif

    neuron_act dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .bias_din   (bias_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_idx   (dout_idx),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic write_bias(input logic [2:0] a, input logic signed [15:0] v);
        bias_we   = 1'b1;
        bias_addr = a;
        bias_din  = v;
        tick();
        bias_we   = 1'b0;
    endtask

    // Single input with ready high: checks the two-edge latency and the result.
    task automatic send(input string tag, input logic signed [31:0] v,
                        input longint exp_v, input longint exp_i);
        din       = v;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        check({tag, "_lat"}, dout_valid, 0);
        tick();
        check({tag, "_valid"}, dout_valid, 1);
        check({tag, "_dout"}, dout, exp_v);
        check({tag, "_idx"}, dout_idx, exp_i);
    endtask

    initial begin
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        bias_we    = 1'b0;
        bias_addr  = '0;
        bias_din   = '0;
        dout_ready = 1'b1;
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_idx", dout_idx, 0);
        check("rst_ovf", overflow, 0);
        tick();
        tick();
        rst = 1'b1;

        // Bias add, activation, saturation and truncation.
        write_bias(3'd0, 16'sd2048);
        send("bias_add", 32'sd262144, 6144, 0);
        send("neg", -32'sd524288, NEG_EXP, 1);
        send("sat_pos", 32'sd2097152, 32767, 2);
        send("trunc", 32'sd393279, 6144, 3);
        send("sat_neg", 32'sh8000_0000, BIG_NEG_EXP, 4);

        // Same-cycle bias write at the address stage 1 reads: old value (0) is used.
        din       = '0;
        din_valid = 1'b1;
        bias_we   = 1'b1;
        bias_addr = 3'd5;
        bias_din  = 16'sd4096;
        tick();
        din_valid = 1'b0;
        bias_we   = 1'b0;
        tick();
        tick();
        check("hazard_dout", dout, 0);
        check("hazard_idx", dout_idx, 5);

        // Index wrap with sustained throughput.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            write_bias(3'(k), 16'(k * 4096));
        end
        din       = '0;
        din_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 10) din_valid = 1'b0;
            if (c >= 3) begin
                check($sformatf("wrap%0d_valid", c - 3), dout_valid, 1);
                check($sformatf("wrap%0d_dout", c - 3), dout, ((c - 3) % 8) * 4096);
                check($sformatf("wrap%0d_idx", c - 3), dout_idx, (c - 3) % 8);
            end
        end
        tick();
        check("wrap_empty", dout_valid, 0);

        // Backpressure: five inputs into a four-entry FIFO.
        do_reset();
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 32'((i + 1) * 262144);
            tick();
        end
        din_valid = 1'b0;
        tick();
        check("bp_hold_dout", dout, 4096);
        check("bp_ovf_before", overflow, 0);
        tick();
        check("bp_ovf_after", overflow, 1);
        check("bp_hold_idx", dout_idx, 0);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), dout_valid, 1);
            check($sformatf("drain%0d_dout", i), dout, (i + 1) * 4096);
            check($sformatf("drain%0d_idx", i), dout_idx, i);
            tick();
        end
        check("drain_empty", dout_valid, 0);
        check("drain_ovf_sticky", overflow, 1);

        // Asynchronous reset with two words buffered.
        write_bias(3'd0, 16'sd2048);
        dout_ready = 1'b0;
        din        = '0;
        din_valid  = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        check("ar_pre_valid", dout_valid, 1);
        check("ar_pre_idx", dout_idx, 5);
        #3;
        rst = 1'b0;
        #1;
        check("ar_valid", dout_valid, 0);
        check("ar_ovf", overflow, 0);
        check("ar_idx", dout_idx, 0);
        tick();
        rst        = 1'b1;
        dout_ready = 1'b1;
        send("ar_post", 32'sd262144, 4096, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/neuron_act.md
# neuron_act

Post-accumulation stage of the neuron datapath. Consumes each finished dot product from the signed accumulator (`dout`/`dout_valid`), adds a per-neuron bias from a local register bank, applies ReLU, requantizes to the output fixed-point format with saturation and buffers results in a small FIFO behind a valid/ready output. The accumulator cannot be stalled, so this block absorbs its output unconditionally and flags any loss.

## Interface
- `DIN_WIDTH`, 32, accumulator word width
- `DIN_INT`, 14, integer bits of din (frac = 18)
- `BIAS_WIDTH`, 16, bias word width
- `BIAS_INT`, 4, integer bits of bias (frac = 12)
- `DOUT_WIDTH`, 16, output word width
- `DOUT_INT`, 4, integer bits of dout (frac = 12)
- `N_NEURONS`, 8, bias bank depth / neuron index modulus
- `FIFO_DEPTH`, 4, output buffer entries (power of 2)
- `clk` in 1, sole clock, rising edge
- `rst` in 1, asynchronous, active-low reset
- `din` in DIN_WIDTH, signed accumulated sum
- `din_valid` in 1, din qualifier (from accumulator dout_valid)
- `bias_we` in 1, bias bank write enable
- `bias_addr` in clog2(N_NEURONS), bias write address
- `bias_din` in BIAS_WIDTH, signed bias value
- `dout` out DOUT_WIDTH, signed activated output (FIFO head)
- `dout_valid` out 1, FIFO non-empty
- `dout_ready` in 1, downstream accept
- `dout_idx` out clog2(N_NEURONS), neuron index of `dout`
- `overflow` out 1, sticky: a result was dropped

## Operation
- Legal parameters: DIN_INT ≥ BIAS_INT; din frac ≥ bias frac; din frac ≥ dout frac. Anything else is unsupported.
- Neuron counter `idx`: 0 at reset. Increments on every `din_valid`; wraps from N_NEURONS-1 to 0.
- Stage 1 (registered): `sum = din + (bias[idx] <<< (din_frac - bias_frac))`. The sum is DIN_WIDTH+1 bits wide so it cannot overflow. `idx` travels with the sum.
- Stage 2 (registered into FIFO):
  - ReLU: a negative sum becomes 0.
  - Requantize by arithmetic shift right of (din_frac - dout_frac), i.e. truncation toward −inf.
  - Saturate to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1].
  - Push {value, idx} into the FIFO.
- Bias bank: N_NEURONS registers, 0 at reset. A write takes effect the edge after `bias_we`. If the write hits the same address that stage 1 reads in the same cycle, stage 1 uses the old value.
- FIFO:
  - Pop on `dout_valid && dout_ready`.
  - Push when full is accepted only if a pop occurs in the same cycle. Otherwise the result is dropped and `overflow` sets and stays set until reset.
  - Simultaneous push and pop with the FIFO non-empty: occupancy is unchanged.
- Reset mid-operation flushes the pipeline and FIFO, clears the bias bank and clears `idx`.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `dout_idx`=0, `overflow`=0.
- Latency: `din_valid` sampled at edge N gives `dout_valid`=1 after edge N+2 when the FIFO is empty.
- Throughput: one result per cycle sustained while `dout_ready`=1.
- `dout` and `dout_idx` hold steady while `dout_valid && !dout_ready`.
- `overflow` rises after the edge at which the drop occurs.
- All outputs are driven from registers; there is no combinational path from `dout_ready` to any output except through the FIFO pointers.

## Configuration
- `LEAKY_RELU_EN`
  - Defined: a negative sum becomes `sum >>> 3` (slope 1/8), applied before requantization and saturation.
  - Undefined: plain ReLU; a negative sum becomes 0.

## Test plan
- Basic bias add:
  - Stimulus: bias[0]=2048 (0.5); din=262144 (1.0) at idx 0; `dout_ready`=1.
  - Response: dout=6144 (1.5), dout_idx=0, two cycles after input.
- Negative input:
  - Stimulus: din=−524288 (−2.0) with bias 0.
  - Response: dout=0. With LEAKY_RELU_EN: dout=−1024 (−0.25).
- Saturation:
  - Stimulus: din=8·2^18 with bias 0.
  - Response: dout=32767.
  - Also: with LEAKY_RELU_EN, a very large negative din gives dout=−32768.
- Index wrap:
  - Stimulus: bias[k]=k·4096 for k=0..7; ten din=0 inputs.
  - Response: dout = 0,4096,…,28672, then 0,4096; dout_idx = 0..7,0,1.
- Backpressure and overflow:
  - Stimulus: `dout_ready`=0 for 5 back-to-back inputs.
  - Response: the first 4 are held in order; `overflow`=1 after the 5th.
  - Then raise ready: exactly 4 words drain in order, then `dout_valid`=0.
- Async reset:
  - Stimulus: assert `rst`=0 mid-stream with the FIFO holding 2 words.
  - Response: `dout_valid`, `overflow` and `dout_idx` clear immediately without a clock. After release, the next din uses idx 0 with bias 0.
